k_wctl_t3: RTL and testbench
============================

// Module: k_wctl_t3
// PURPOSE
//  Write-side control for the async FIFO, next generation of the write-control block.
//  - Owns the binary and Gray write pointers, the memory write address and a registered full flag.
//  - Adds a programmable almost-full flag, a write-side fill level and a sticky overflow error.
//  - Gates the memory write strobe internally, so pushes while full are dropped and flagged.
//  - Sits in the wclk domain. Its inputs are the push request and the Gray read pointer after the 2-flop synchroniser.
// PARAMETERS
//  addr_size    4  memory address width; DEPTH = 2**addr_size
//  afull_margin 2  wafull asserts when level >= DEPTH - afull_margin; legal range 1..DEPTH-1
// PORTS
//  wclk      in   1            write clock
//  wrst_n    in   1            asynchronous active-low reset
//  wput      in   1            push request
//  wq2_rptr  in   addr_size+1  Gray read pointer, already synchronised into wclk
//  ovf_clr   in   1            clears the sticky overflow flag
//  wen       out  1            memory write strobe, = wput & ~wfull
//  waddr     out  addr_size    memory write address
//  wptr      out  addr_size+1  Gray write pointer, registered, sent to the read-side synchroniser
//  wfull     out  1            FIFO full, registered
//  wafull    out  1            FIFO almost full, registered
//  wlevel    out  addr_size+1  write-side fill level, 0..DEPTH, registered
//  wovf      out  1            sticky overflow: a push was attempted while full
// BEHAVIOUR
//  - Reset (async assert, sync release to wclk): wbin, wptr, wlevel = 0; wfull, wafull, wovf = 0.
//    wen = 0 while wput = 0.
//  - wen is combinational: wen = wput & ~wfull.
//  - bnext = wbin + wen, modulo 2**(addr_size+1).
//    gnext = (bnext >> 1) ^ bnext.
//    On every wclk edge: wbin <= bnext; wptr <= gnext.
//  - waddr = wbin[addr_size-1:0], so the address increments one cycle after each accepted write.
//  - Full flag:
//    - wfull <= (gnext == {~wq2_rptr[addr_size:addr_size-1], wq2_rptr[addr_size-2:0]}).
//    - wfull rises on the edge that accepts the DEPTH-th unread word.
//    - wfull falls on the first edge after wq2_rptr advances.
//  - Fill level:
//    - rbin = Gray-to-binary of wq2_rptr, combinational.
//    - wlevel <= bnext - rbin, modulo 2**(addr_size+1).
//    - The level is pessimistic (over-reports) by the synchroniser delay. It is never under-reported.
//  - Almost-full: wafull <= (bnext - rbin) >= DEPTH - afull_margin. Same edge timing as wlevel.
//  - Overflow:
//    - wput & wfull sets wovf on the next edge.
//    - ovf_clr clears wovf only when no new overflow occurs in the same cycle. Set wins over clear.
//    - A dropped push leaves wbin, wptr and wlevel unchanged.
//  - Wrap-around: the pointers roll over from 2**(addr_size+1)-1 to 0. Full and level stay correct across the wrap.
//  - Simultaneous events:
//    - A push while full in the same cycle that wq2_rptr advances is still dropped, because wfull is registered.
//    - A push and a read-pointer advance in one cycle leave the level unchanged.
//  - Reset mid-operation: everything returns to the reset values immediately (asynchronous).
//    The read side is reset by the same FIFO reset.
//  - The wq2_rptr inputs are sampled only through registered paths. This block instantiates no synchroniser.
// STRUCTURE
//  - Shared package k_fifo_pkg:
//    - bin2gray and gray2bin functions, parametrised by width.
//    - DEPTH localparam derivation.
//  - Sub-module k_ptr_t2 (addr_size):
//    - contents: binary/Gray pointer register with inc, returns bnext/gnext.
//    - read side reuses it with inc = rget & ~rempty.
//  - Flag, level and overflow logic live inline in k_wctl_t3.
//  - Elaboration check: fatal if afull_margin < 1 or afull_margin > DEPTH-1.
// TESTING
//  Defaults (addr_size=4, DEPTH=16, afull_margin=2).
//  1. Reset:
//     - wrst_n low with wput=1 -> all outputs 0.
//     - after release, wput=1 for one cycle -> waddr=1, wptr=5'b00001, wlevel=1.
//  2. Fill, wq2_rptr=0, 16 consecutive wput:
//     - wafull=1 from the edge where wlevel=14.
//     - wfull=1 and wlevel=16 after the 16th edge.
//     - waddr=0, wptr=5'b11000.
//  3. Overflow:
//     - while full, wput=1 for 3 cycles -> wen=0, wptr/wlevel unchanged, wovf=1 and held.
//     - ovf_clr=1 with wput=0 -> wovf=0.
//     - ovf_clr=1 with wput=1 while full -> wovf stays 1.
//  4. Drain and level:
//     - drive wq2_rptr to Gray(4) -> next edge wfull=0, wlevel=12, wafull=0.
//     - push and advance rptr in the same cycle -> wlevel stays 12.
//  5. Wrap-around:
//     - stream 40 pushes, with wq2_rptr kept 3 behind.
//     - wbin rolls over 31->0, wptr is always a single-bit Gray step, wlevel=3 throughout, no false wfull.
//  6. Reset mid-fill:
//     - assert wrst_n low asynchronously between edges at wlevel=9 -> all outputs 0 at once.
//     - refill behaves as scenario 2.

Source files
------------

// File: rtl/k_fifo_pkg.sv
// Shared async-FIFO helpers: depth derivation and Gray/binary conversion.
// The conversions are width-generic: callers zero-extend into PTR_MAX_W bits and keep the low bits.
package k_fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    function automatic int unsigned fifo_depth(input int unsigned addr_size);
        return 32'd1 << addr_size;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/k_ptr_t2.sv
// Binary + Gray pointer pair with an increment enable; shared by the write and read controls.
// Exposes the next-state values so the owner can build registered flags from them.
module k_ptr_t2
    import k_fifo_pkg::*;
#(
    parameter int unsigned addr_size = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc_i,
    output logic [addr_size:0] bin_o,
    output logic [addr_size:0] gray_o,
    output logic [addr_size:0] bnext_o,
    output logic [addr_size:0] gnext_o
);

    localparam int unsigned PW = addr_size + 1;

    logic [PW-1:0]        bin_q;
    logic [PW-1:0]        gray_q;
    logic [PW-1:0]        bnext_d;
    logic [PW-1:0]        gnext_d;
    logic [PTR_MAX_W-1:0] gray_ext;
    logic                 unused_gray_hi;

    assign bnext_d        = bin_q + PW'(inc_i);
    assign gray_ext       = bin2gray(PTR_MAX_W'(bnext_d));
    assign gnext_d        = gray_ext[PW-1:0];
    assign unused_gray_hi = |gray_ext[PTR_MAX_W-1:PW];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bnext_d;
            gray_q <= gnext_d;
        end
    end

    assign bin_o   = bin_q;
    assign gray_o  = gray_q;
    assign bnext_o = bnext_d;
    assign gnext_o = gnext_d;

endmodule

// File: rtl/k_wctl_t3.sv
// Write-side control of the async FIFO: pointers, registered full/almost-full/level and sticky overflow.
// wrst_n is expected to be released synchronously to wclk by the FIFO's reset bridge.
module k_wctl_t3
    import k_fifo_pkg::*;
#(
    parameter int unsigned addr_size    = 4,
    parameter int unsigned afull_margin = 2
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 wput,
    input  logic [addr_size:0]   wq2_rptr,
    input  logic                 ovf_clr,
    output logic                 wen,
    output logic [addr_size-1:0] waddr,
    output logic [addr_size:0]   wptr,
    output logic                 wfull,
    output logic                 wafull,
    output logic [addr_size:0]   wlevel,
    output logic                 wovf
);

    localparam int unsigned PW                 = addr_size + 1;
    localparam int unsigned DEPTH              = fifo_depth(addr_size);
    localparam logic [PW-1:0] AFULL_THRESH     = PW'(DEPTH - afull_margin);

    if (afull_margin < 1 || afull_margin > DEPTH - 1) begin : g_bad_margin
        $fatal(1, "k_wctl_t3: afull_margin must lie in 1..DEPTH-1");
    end

    logic [PW-1:0]        wbin;
    logic [PW-1:0]        bnext;
    logic [PW-1:0]        gnext;
    logic [PW-1:0]        rbin;
    logic [PTR_MAX_W-1:0] rbin_ext;
    logic [PW-1:0]        level_d;
    logic                 unused_ok;

    logic          wfull_q,  wfull_d;
    logic          wafull_q, wafull_d;
    logic [PW-1:0] wlevel_q;
    logic          wovf_q,   wovf_d;

    // Registered full flag makes a push in the cycle the read pointer moves still drop.
    assign wen = wput & ~wfull_q;

    k_ptr_t2 #(
        .addr_size (addr_size)
    ) u_wptr (
        .clk     (wclk),
        .rst_n   (wrst_n),
        .inc_i   (wen),
        .bin_o   (wbin),
        .gray_o  (wptr),
        .bnext_o (bnext),
        .gnext_o (gnext)
    );

    assign waddr     = wbin[addr_size-1:0];
    assign rbin_ext  = gray2bin(PTR_MAX_W'(wq2_rptr));
    assign rbin      = rbin_ext[PW-1:0];
    assign unused_ok = ^{rbin_ext[PTR_MAX_W-1:PW], wbin[addr_size]};

    // Level uses the synchronised (stale) read pointer, so it can only over-report.
    assign level_d  = bnext - rbin;
    assign wfull_d  = (gnext == {~wq2_rptr[addr_size:addr_size-1], wq2_rptr[addr_size-2:0]});
    assign wafull_d = (level_d >= AFULL_THRESH);
    assign wovf_d   = (wput & wfull_q) | (wovf_q & ~ovf_clr);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wlevel_q <= level_d;
            wovf_q   <= wovf_d;
        end
    end

    assign wfull  = wfull_q;
    assign wafull = wafull_q;
    assign wlevel = wlevel_q;
    assign wovf   = wovf_q;

endmodule

// File: tb/tb_k_wctl_t3.sv
// Bench for k_wctl_t3: directed scenarios plus randomized traffic against an occupancy-count model.
module tb_k_wctl_t3;

    localparam int AW     = 4;
    localparam int PW     = AW + 1;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;

    logic          wclk     = 1'b0;
    logic          wrst_n   = 1'b1;
    logic          wput     = 1'b0;
    logic          ovf_clr  = 1'b0;
    logic [PW-1:0] wq2_rptr = '0;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          wfull;
    logic          wafull;
    logic [PW-1:0] wlevel;
    logic          wovf;

    int checks = 0;
    int passes = 0;

    // Model: words ever written / words the write side believes were read, as plain integers.
    int   wr_cnt, rd_cnt, m_level;
    bit   m_full, m_afull, m_ovf;
    bit   cur_put;
    logic pre_edge_wen;
    bit   pre_edge_exp;

    always #5 wclk = ~wclk;

    k_wctl_t3 #(
        .addr_size    (AW),
        .afull_margin (MARGIN)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .wput     (wput),
        .wq2_rptr (wq2_rptr),
        .ovf_clr  (ovf_clr),
        .wen      (wen),
        .waddr    (waddr),
        .wptr     (wptr),
        .wfull    (wfull),
        .wafull   (wafull),
        .wlevel   (wlevel),
        .wovf     (wovf)
    );

    function automatic logic [PW-1:0] gray_of(input int n);
        logic [PW-1:0] b;
        b = PW'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    function automatic logic [17:0] dut_vec();
        return {wen, waddr, wptr, wfull, wafull, wlevel, wovf};
    endfunction

    function automatic logic [17:0] exp_vec();
        logic [PW-1:0] b;
        b = PW'(wr_cnt % (2 * DEPTH));
        return {1'(cur_put && !m_full), b[AW-1:0], gray_of(wr_cnt), 1'(m_full), 1'(m_afull),
                PW'(m_level), 1'(m_ovf)};
    endfunction

    task automatic model_reset();
        wr_cnt  = 0;
        rd_cnt  = 0;
        m_level = 0;
        m_full  = 1'b0;
        m_afull = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One wclk cycle: drive inputs, capture pre-edge wen, advance the model on the edge.
    task automatic step(input bit put, input bit clr, input int rd);
        cur_put  = put;
        wput     = put;
        ovf_clr  = clr;
        rd_cnt   = rd;
        wq2_rptr = gray_of(rd);
        #1;
        pre_edge_wen = wen;
        pre_edge_exp = put && !m_full;
        @(posedge wclk);
        m_ovf = (put && m_full) || (m_ovf && !clr);
        if (put && !m_full) wr_cnt++;
        m_level = wr_cnt - rd_cnt;
        m_full  = (m_level == DEPTH);
        m_afull = (m_level >= DEPTH - MARGIN);
        #1;
    endtask

    task automatic test_reset();
        wput     = 1'b1;
        ovf_clr  = 1'b0;
        wq2_rptr = '0;
        #2 wrst_n = 1'b0;
        #1;
        checks++;
        if ({waddr, wptr, wfull, wafull, wlevel, wovf} !== 17'd0)
            $display("FAIL reset_regs: got %h expected 0", {waddr, wptr, wfull, wafull, wlevel, wovf});
        else passes++;
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wput = 1'b0;
        #1;
        checks++;
        if (wen !== 1'b0) $display("FAIL reset_wen: got %b expected 0", wen);
        else passes++;
        @(negedge wclk);
        wrst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 0);
        checks++;
        if ({waddr, wptr, wlevel} !== {4'd1, 5'b00001, 5'd1})
            $display("FAIL reset_first_push: waddr=%0d wptr=%b wlevel=%0d expected 1 00001 1", waddr, wptr, wlevel);
        else passes++;
        checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_vec: got %h expected %h", dut_vec(), exp_vec());
        else passes++;
    endtask

    // Assumes an empty FIFO with the read pointer at 0.
    task automatic test_fill(input string tag);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 0);
            checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL %s_vec[%0d]: got %h expected %h", tag, i, dut_vec(), exp_vec());
            else passes++;
            if (i == 13 || i == 14) begin
                checks++;
                if (wafull !== 1'(i == 14))
                    $display("FAIL %s_afull[%0d]: got %b expected %b", tag, i, wafull, i == 14);
                else passes++;
            end
        end
        checks++;
        if ({wfull, wlevel, waddr, wptr} !== {1'b1, 5'd16, 4'd0, 5'b11000})
            $display("FAIL %s_full: wfull=%b wlevel=%0d waddr=%0d wptr=%b expected 1 16 0 11000",
                     tag, wfull, wlevel, waddr, wptr);
        else passes++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 0);
            checks++;
            if ({pre_edge_wen, wptr, wlevel, wovf} !== {1'b0, 5'b11000, 5'd16, 1'b1})
                $display("FAIL ovf_drop[%0d]: wen=%b wptr=%b wlevel=%0d wovf=%b expected 0 11000 16 1",
                         i, pre_edge_wen, wptr, wlevel, wovf);
            else passes++;
        end
        step(1'b0, 1'b0, 0);
        checks++;
        if (wovf !== 1'b1) $display("FAIL ovf_hold: got %b expected 1", wovf);
        else passes++;
        step(1'b0, 1'b1, 0);
        checks++;
        if (wovf !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", wovf);
        else passes++;
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        checks++;
        if (wovf !== 1'b1) $display("FAIL ovf_set_wins: got %b expected 1", wovf);
        else passes++;
        step(1'b0, 1'b1, 0);
        checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL ovf_vec: got %h expected %h", dut_vec(), exp_vec());
        else passes++;
    endtask

    task automatic test_drain();
        step(1'b0, 1'b0, 4);
        checks++;
        if ({wfull, wlevel, wafull} !== {1'b0, 5'd12, 1'b0})
            $display("FAIL drain: wfull=%b wlevel=%0d wafull=%b expected 0 12 0", wfull, wlevel, wafull);
        else passes++;
        step(1'b1, 1'b0, 5);
        checks++;
        if ({pre_edge_wen, wlevel, waddr} !== {1'b1, 5'd12, 4'd1})
            $display("FAIL push_and_read: wen=%b wlevel=%0d waddr=%0d expected 1 12 1", pre_edge_wen, wlevel, waddr);
        else passes++;
        checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL drain_vec: got %h expected %h", dut_vec(), exp_vec());
        else passes++;
    endtask

    task automatic test_wrap();
        logic [PW-1:0] prev;
        step(1'b0, 1'b0, wr_cnt - 3);
        for (int i = 0; i < 40; i++) begin
            prev = wptr;
            step(1'b1, 1'b0, rd_cnt + 1);
            checks++;
            if (wlevel !== 5'd3 || wfull !== 1'b0 || $countones(wptr ^ prev) != 1)
                $display("FAIL wrap[%0d]: wlevel=%0d wfull=%b wptr %b->%b expected level 3, not full, one-bit step",
                         i, wlevel, wfull, prev, wptr);
            else passes++;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL wrap_vec[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            else passes++;
        end
    endtask

    task automatic test_random();
        bit put, clr;
        int rd, room;
        for (int i = 0; i < 400; i++) begin
            put  = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 7) == 0);
            rd   = rd_cnt;
            room = wr_cnt - rd_cnt;
            // Reads are slower in the first half (fills up), faster in the second (drains).
            if (room > 0 && $urandom_range(0, 2) < ((i < 200) ? 1 : 3))
                rd += $urandom_range(1, (room < 2) ? room : 2);
            step(put, clr, rd);
            checks++;
            if (pre_edge_wen !== pre_edge_exp)
                $display("FAIL rand_wen[%0d]: got %b expected %b", i, pre_edge_wen, pre_edge_exp);
            else passes++;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL rand_vec[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge wclk);
        wrst_n = 1'b0;
        wput = 1'b0;
        ovf_clr = 1'b0;
        wq2_rptr = '0;
        model_reset();
        @(negedge wclk);
        wrst_n = 1'b1;
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 0);
        checks++;
        if (wlevel !== 5'd9) $display("FAIL mid_level: got %0d expected 9", wlevel);
        else passes++;
        #2;
        wput = 1'b0;
        wrst_n = 1'b0;
        #1;
        checks++;
        if ({wen, waddr, wptr, wfull, wafull, wlevel, wovf} !== 18'd0)
            $display("FAIL mid_reset: got %h expected 0", {wen, waddr, wptr, wfull, wafull, wlevel, wovf});
        else passes++;
        model_reset();
        @(negedge wclk);
        wrst_n = 1'b1;
        test_fill("refill");
    endtask

    initial begin
        model_reset();
        cur_put = 1'b0;
        test_reset();
        test_reset_mid();
        test_overflow();
        test_drain();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
